hamming74_byte_ctrl: RTL and testbench
======================================

# hamming74_byte_ctrl

Byte-stream sequencer for the Hamming(7,4) codec. It accepts bytes or codewords over a valid/ready input port and splits or merges nibbles. It runs one shared encode/correct datapath per nibble and returns codewords or corrected bytes over a valid/ready output port, counting corrected single-bit errors. It sits between the 8-bit pin interface and the combinational Hamming(7,4) encoder/decoder, replacing the per-nibble manual mode pin with a byte-level transaction engine.

## Interface
- ERR_CNT_W, default 8: width of the saturating corrected-error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = encode, 1 = decode; sampled only on an input handshake in IDLE.
- in_valid  in  1  input item present.
- in_ready  out  1  block can accept an input item.
- in_data  in  8  encode: data byte; decode: codeword in [6:0], bit 7 ignored.
- out_valid  out  1  output item present.
- out_ready  in  1  downstream accepts output item.
- out_data  out  8  encode: {1'b0, codeword}; decode: corrected byte.
- out_err  out  1  decode only: at least one nibble of the current byte was corrected; 0 in encode.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  ERR_CNT_W  corrected codewords since reset/clear, saturating at all-ones.

## Operation
Codeword format, bit c0..c6 = p1 p2 d1 p3 d2 d3 d4, where d1..d4 = nibble[0..3]:
- p1 = d1^d2^d4
- p2 = d1^d3^d4
- p3 = d2^d3^d4

Decode:
- Syndrome s = {c3^c4^c5^c6, c1^c2^c5^c6, c0^c2^c4^c6}.
- s != 0: flip bit c[s-1], then extract data.
- Double errors are miscorrected silently (Hamming(7,4) limit).

Handshake and outputs:
- Handshake occurs on a cycle with valid & ready both high.
- All outputs are registered.
- out_data and out_err hold stable while out_valid=1 and out_ready=0.

FSM states:
- IDLE: in_ready=1, out_valid=0.
  - Handshake with mode=0 latches the byte -> ENC_LO.
  - Handshake with mode=1 latches the corrected low nibble and its error flag -> DEC_WAIT.
- ENC_LO: out_valid=1, out_data=enc(byte[3:0]). On out_ready -> ENC_HI.
- ENC_HI: out_valid=1, out_data=enc(byte[7:4]). On out_ready -> IDLE.
- DEC_WAIT: in_ready=1. On handshake, latch the corrected high nibble -> DEC_OUT. mode is ignored in this state.
- DEC_OUT: out_valid=1, out_data={hi,lo}, out_err = OR of both nibble flags. On out_ready -> IDLE.

Other rules:
- in_ready=0 in ENC_LO, ENC_HI and DEC_OUT; there is no overlap of input acceptance with output.
- err_count increments by 1 on each accepted decode codeword with s != 0.
  - At all-ones it holds (saturates).
  - err_clr in the same cycle as an increment: clear wins, err_count=0.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, err_count=0, all latched nibbles 0.

## Timing
- Encode, out_ready held high: byte accepted at T.
  - Low codeword valid T+1, high codeword valid T+2.
  - Back in IDLE with in_ready=1 at T+3.
- Decode, in_valid and out_ready held high: low codeword at T, high codeword at T+1.
  - Byte valid at T+2; in_ready=1 at T+3.
- Backpressure: each out_ready=0 cycle adds one cycle of stall with outputs frozen.
- A DEC_WAIT gap of any length is permitted; no timeout.
- Reset asserted in any state, including mid-transaction: at the next edge, every output takes its reset value and the partial transaction is discarded.
- err_count becomes visible the cycle after the accepting handshake.

## Test plan
- Encode 0xA5, out_ready=1 -> out_data 0x2D at T+1, 0x52 at T+2, out_valid=0 at T+3; encode 0x00 -> 0x00, 0x00; encode 0xFF -> 0x7F, 0x7F.
- Decode 0x2D then 0x52 -> out_data 0xA5, out_err=0, err_count unchanged.
- Decode 0x29 (bit 2 flipped) then 0x52 -> 0xA5, out_err=1, err_count=1; decode 0x2D then 0x12 (bit 6 flipped) -> 0xA5, out_err=1, err_count=2.
- Backpressure: encode 0xA5 with out_ready=0 for 5 cycles -> out_data stays 0x2D, out_valid=1, in_ready=0; release -> 0x52 next.
- Saturation/clear with ERR_CNT_W=2: 4 corrupted codewords -> err_count=3; err_clr coincident with a 5th corrected codeword -> err_count=0.
- Reset in ENC_HI and in DEC_WAIT -> next cycle out_valid=0, in_ready=1, err_count=0; following decode of 0x2D, 0x52 yields 0xA5, not a stale nibble.

Source files
------------

// File: rtl/hamming74_byte_if.sv
// Byte-level valid/ready bus of the Hamming(7,4) sequencer, plus the
// corrected-error counter's clear input and count output.
interface hamming74_byte_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_err;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output mode, in_valid, in_data, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_err, err_count
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_err, err_count
  );
endinterface

// File: rtl/hamming74_byte_ctrl.sv
// Byte-stream sequencer around a shared Hamming(7,4) encode/correct datapath:
// a byte becomes two codewords, two codewords become one corrected byte.
module hamming74_byte_ctrl #(
  parameter int ERR_CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  hamming74_byte_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENC_LO   = 3'd1,
    ENC_HI   = 3'd2,
    DEC_WAIT = 3'd3,
    DEC_OUT  = 3'd4
  } state_t;

  // Codeword bits c6..c0 = d4 d3 d2 p3 d1 p2 p1.
  function automatic logic [6:0] encode(input logic [3:0] n);
    logic p1, p2, p3;
    p1 = n[0] ^ n[1] ^ n[3];
    p2 = n[0] ^ n[2] ^ n[3];
    p3 = n[1] ^ n[2] ^ n[3];
    return {n[3], n[2], n[1], p3, n[0], p2, p1};
  endfunction

  // Returns {corrected, nibble}; the syndrome names the 1-based bad bit.
  function automatic logic [4:0] correct(input logic [6:0] cw);
    logic [2:0] s;
    logic [6:0] c;
    c = cw;
    s = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
         cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
         cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
    return {(s != 3'd0), c[6], c[5], c[4], c[2]};
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           byte_q, byte_d;
  logic [3:0]           lo_q, lo_d, hi_q, hi_d;
  logic                 lo_err_q, lo_err_d, hi_err_q, hi_err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 in_fire, out_fire, dec_take;
  logic [4:0]           corr;
  logic [3:0]           enc_nib;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign corr     = correct(bus.in_data[6:0]);
  assign dec_take = in_fire & (((state_q == IDLE) & bus.mode) | (state_q == DEC_WAIT));

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      lo_err_q    <= 1'b0;
      hi_err_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      lo_err_q    <= lo_err_d;
      hi_err_q    <= hi_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (in_fire)  state_d = bus.mode ? DEC_WAIT : ENC_LO;
      ENC_LO:   if (out_fire) state_d = ENC_HI;
      ENC_HI:   if (out_fire) state_d = IDLE;
      DEC_WAIT: if (in_fire)  state_d = DEC_OUT;
      DEC_OUT:  if (out_fire) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic: latches and the next registered outputs, keyed on state_d.
  always_comb begin
    byte_d      = byte_q;
    lo_d        = lo_q;
    lo_err_d    = lo_err_q;
    hi_d        = hi_q;
    hi_err_d    = hi_err_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;

    if (in_fire && state_q == IDLE && !bus.mode) byte_d = bus.in_data;
    if (in_fire && state_q == IDLE && bus.mode) begin
      lo_d     = corr[3:0];
      lo_err_d = corr[4];
    end
    if (in_fire && state_q == DEC_WAIT) begin
      hi_d     = corr[3:0];
      hi_err_d = corr[4];
    end

    // One encoder serves both halves of the byte.
    enc_nib = (state_d == ENC_HI) ? byte_d[7:4] : byte_d[3:0];

    unique case (state_d)
      IDLE, DEC_WAIT: in_ready_d = 1'b1;
      ENC_LO, ENC_HI: begin
        out_valid_d = 1'b1;
        out_data_d  = {1'b0, encode(enc_nib)};
        out_err_d   = 1'b0;
      end
      DEC_OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = {hi_d, lo_d};
        out_err_d   = lo_err_d | hi_err_d;
      end
      default: in_ready_d = 1'b1;
    endcase

    // Clear outranks a same-cycle increment; the count sticks at all-ones.
    if (bus.err_clr)                              err_count_d = '0;
    else if (dec_take && corr[4] && ~&err_count_q) err_count_d = err_count_q + 1'b1;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_hamming74_byte_ctrl.sv
// Directed and randomized checks of hamming74_byte_ctrl against a
// nearest-codeword reference model, with a 2-bit error counter.
module tb_hamming74_byte_ctrl;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_cnt = 0;

  hamming74_byte_if #(.ERR_CNT_W(W)) bus ();
  hamming74_byte_ctrl #(.ERR_CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of test, expected end before 2ms");
    $fatal(1, "watchdog expired");
  end

  // Reference: codeword from the parity rules, decode by nearest codeword.
  function automatic logic [6:0] m_enc(input logic [3:0] n);
    logic [6:0] c;
    c = '0;
    c[2] = n[0]; c[4] = n[1]; c[5] = n[2]; c[6] = n[3];
    c[0] = n[0] ^ n[1] ^ n[3];
    c[1] = n[0] ^ n[2] ^ n[3];
    c[3] = n[1] ^ n[2] ^ n[3];
    return c;
  endfunction

  function automatic logic [4:0] m_dec(input logic [6:0] cw);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = $countones(m_enc(4'(i)) ^ cw);
      if (d <= 1) r = {(d != 0), 4'(i)};
    end
    return r;
  endfunction

  function automatic logic [6:0] rand_mask();
    int k1, k2;
    logic [6:0] m;
    m  = '0;
    k1 = $urandom_range(0, 6);
    k2 = (k1 + 1 + $urandom_range(0, 5)) % 7;
    case ($urandom_range(0, 3))
      1, 2:    m[k1] = 1'b1;
      3:       begin m[k1] = 1'b1; m[k2] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_codeword(input logic err, input logic clr);
    if (clr)                    m_cnt = 0;
    else if (err && m_cnt < 3)  m_cnt++;
  endtask

  task automatic do_encode(input logic [7:0] b, input int stall);
    logic [7:0] lo_exp, hi_exp;
    lo_exp = {1'b0, m_enc(b[3:0])};
    hi_exp = {1'b0, m_enc(b[7:4])};
    bus.mode = 1'b0; bus.in_data = b; bus.in_valid = 1'b1;
    check("enc_accept_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("enc_stall_valid", bus.out_valid, 1);
      check("enc_stall_data", bus.out_data, lo_exp);
      check("enc_stall_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    check("enc_lo_valid", bus.out_valid, 1);
    check("enc_lo_data", bus.out_data, lo_exp);
    check("enc_lo_err", bus.out_err, 0);
    tick();
    check("enc_hi_valid", bus.out_valid, 1);
    check("enc_hi_data", bus.out_data, hi_exp);
    check("enc_hi_in_ready", bus.in_ready, 0);
    tick();
    check("enc_done_valid", bus.out_valid, 0);
    check("enc_done_in_ready", bus.in_ready, 1);
    check("enc_err_count", bus.err_count, m_cnt);
  endtask

  task automatic do_decode(input logic [6:0] lo_cw, input logic [6:0] hi_cw,
                           input int gap, input int stall, input logic clr_hi);
    logic [4:0] lo_r, hi_r;
    logic [7:0] exp_byte;
    lo_r = m_dec(lo_cw);
    hi_r = m_dec(hi_cw);
    exp_byte = {hi_r[3:0], lo_r[3:0]};
    bus.mode = 1'b1; bus.in_data = {1'($urandom), lo_cw}; bus.in_valid = 1'b1;
    check("dec_accept_ready", bus.in_ready, 1);
    tick();
    count_codeword(lo_r[4], 1'b0);
    bus.in_valid = 1'b0; bus.mode = 1'($urandom);
    for (int g = 0; g < gap; g++) begin
      check("dec_wait_in_ready", bus.in_ready, 1);
      check("dec_wait_valid", bus.out_valid, 0);
      check("dec_wait_err_count", bus.err_count, m_cnt);
      tick();
    end
    bus.in_data = {1'($urandom), hi_cw}; bus.mode = 1'($urandom);
    bus.in_valid = 1'b1; bus.err_clr = clr_hi;
    tick();
    count_codeword(hi_r[4], clr_hi);
    bus.in_valid = 1'b0; bus.err_clr = 1'b0;
    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("dec_stall_data", bus.out_data, exp_byte);
      check("dec_stall_err", bus.out_err, lo_r[4] | hi_r[4]);
      check("dec_stall_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    check("dec_out_valid", bus.out_valid, 1);
    check("dec_out_data", bus.out_data, exp_byte);
    check("dec_out_err", bus.out_err, lo_r[4] | hi_r[4]);
    check("dec_out_err_count", bus.err_count, m_cnt);
    check("dec_out_in_ready", bus.in_ready, 0);
    tick();
    check("dec_done_valid", bus.out_valid, 0);
    check("dec_done_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b1; bus.err_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_err_count", bus.err_count, 0);

    // Known encode vectors, cross-checked against literal codewords.
    check("model_enc_5", {1'b0, m_enc(4'h5)}, 8'h2D);
    check("model_enc_a", {1'b0, m_enc(4'hA)}, 8'h52);
    do_encode(8'hA5, 0);
    do_encode(8'h00, 0);
    do_encode(8'hFF, 0);

    // Clean, low-corrupted and high-corrupted decodes.
    do_decode(7'h2D, 7'h52, 0, 0, 1'b0);
    do_decode(7'h29, 7'h52, 0, 0, 1'b0);
    check("dec_err_count_1", bus.err_count, 1);
    do_decode(7'h2D, 7'h12, 0, 0, 1'b0);
    check("dec_err_count_2", bus.err_count, 2);

    do_encode(8'hA5, 5);

    // Saturation at all-ones, then a clear coinciding with a correction.
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0; m_cnt = 0;
    check("clr_err_count", bus.err_count, 0);
    do_decode(7'h29, 7'h12, 0, 0, 1'b0);
    do_decode(7'h29, 7'h12, 1, 0, 1'b0);
    check("sat_err_count", bus.err_count, 3);
    do_decode(7'h2D, 7'h12, 0, 0, 1'b1);
    check("clr_wins_err_count", bus.err_count, 0);

    // Reset while in ENC_HI.
    bus.mode = 1'b0; bus.in_data = 8'h3C; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("pre_rst_enc_hi_data", bus.out_data, {1'b0, m_enc(4'h3)});
    reset = 1'b1; tick(); reset = 1'b0; m_cnt = 0;
    check("rst_enc_hi_valid", bus.out_valid, 0);
    check("rst_enc_hi_in_ready", bus.in_ready, 1);
    check("rst_enc_hi_data", bus.out_data, 0);

    // Reset while in DEC_WAIT holding a corrected, different low nibble.
    bus.mode = 1'b1; bus.in_data = {1'b0, m_enc(4'hC) ^ 7'h01}; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_dec_err_count", bus.err_count, 1);
    reset = 1'b1; tick(); reset = 1'b0; m_cnt = 0;
    check("rst_dec_wait_valid", bus.out_valid, 0);
    check("rst_dec_wait_in_ready", bus.in_ready, 1);
    check("rst_dec_wait_err_count", bus.err_count, 0);
    do_decode(7'h2D, 7'h52, 0, 0, 1'b0);
    check("post_rst_err_count", bus.err_count, 0);

    // Randomized mix of encodes and decodes with errors, gaps and stalls.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_encode(b, $urandom_range(0, 3));
      else
        do_decode(m_enc(b[3:0]) ^ rand_mask(), m_enc(b[7:4]) ^ rand_mask(),
                  $urandom_range(0, 2), $urandom_range(0, 2),
                  1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
